// File: rtl/apb_i2s.sv
// APB3 slave feeding a stereo TX FIFO, serialized as a Philips I2S master (SCK/WS/SD).
// Latency: APB zero wait states; first left MSB on SD 2*(DIV+1) clocks after EN is set.
// Backpressure: TXDATA write to a full FIFO errors (pslverr) and is dropped; empty FIFO at frame start sends zeros and sets UNDERRUN.
module apb_i2s #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] apb_paddr,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic        i2s_sck,
    output logic        i2s_ws,
    output logic        i2s_sd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // APB decode
    logic       access;
    logic       addr_ok;
    logic [1:0] reg_sel;
    logic       wr_ctrl;
    logic       wr_div;
    logic       wr_status;
    logic       wr_txd;

    assign access    = apb_psel & apb_penable;
    assign addr_ok   = (apb_paddr[11:4] == 8'd0);
    assign reg_sel   = apb_paddr[3:2];
    assign wr_ctrl   = access & apb_pwrite & addr_ok & (reg_sel == 2'd0);
    assign wr_div    = access & apb_pwrite & addr_ok & (reg_sel == 2'd1);
    assign wr_status = access & apb_pwrite & addr_ok & (reg_sel == 2'd2);
    assign wr_txd    = access & apb_pwrite & addr_ok & (reg_sel == 2'd3);

    // Registers and state
    logic             en;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       cnt;
    logic [31:0]      shreg;
    logic             underrun;

    // FIFO
    logic [31:0]    mem [FIFO_DEPTH];
    logic [LW-1:0]  wr_ptr;
    logic [LW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           full;
    logic           empty;
    logic           fifo_clr;
    logic           push;
    logic           pop;
    logic [31:0]    head;

    // Serializer control
    logic       run;
    logic       wrap;
    logic       fall;
    logic       load;
    logic [4:0] cnt_nx;

    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign fifo_clr = wr_ctrl & apb_pwdata[1];
    assign pop      = load & ~empty;
    // a pop in the same clock frees the slot, so a push to a full FIFO is still taken
    assign push     = wr_txd & (~full | pop);

    // Disabling takes effect on the write edge itself so no frame start (and pop) slips in.
    assign run    = en & ~(wr_ctrl & ~apb_pwdata[0]);
    assign wrap   = run & (div_cnt == div_act);
    assign fall   = wrap & i2s_sck;
    assign load   = fall & (cnt == 5'd31);
    assign cnt_nx = cnt + 5'd1;

    assign apb_pready  = 1'b1;
    assign apb_pslverr = access & (~addr_ok | (apb_pwrite & (reg_sel == 2'd3) & full & ~pop));

    // Combinational read mux, only driven during a valid access phase
    always_comb begin
        apb_prdata = '0;
        if (access && addr_ok) begin
            case (reg_sel)
                2'd0: apb_prdata[0] = en;
                2'd1: apb_prdata[DIV_W-1:0] = div;
                2'd2: begin
                    apb_prdata[0]   = full;
                    apb_prdata[1]   = empty;
                    apb_prdata[2]   = underrun;
                    apb_prdata[7:4] = 4'(level);
                end
                default: apb_prdata = '0;
            endcase
        end
    end

    // Control registers and sticky underrun flag (set beats W1C)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            en       <= 1'b0;
            div      <= DIV_W'(3);
            underrun <= 1'b0;
        end else begin
            if (wr_ctrl) en <= apb_pwdata[0];
            if (wr_div) div <= apb_pwdata[DIV_W-1:0];
            if (load && empty) underrun <= 1'b1;
            else if (wr_status && apb_pwdata[2]) underrun <= 1'b0;
        end
    end

    // FIFO pointers; clear overrides any push or pop in the same clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LW'(1);
            if (pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // FIFO storage, no reset needed since empty gates every read
    always_ff @(posedge i_clk) begin
        if (push && !fifo_clr) mem[wr_ptr[AW-1:0]] <= apb_pwdata;
    end

    // Bit-clock divider and frame serializer; everything parks at idle when not running
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            div_act <= DIV_W'(3);
            cnt     <= 5'd31;
            shreg   <= '0;
            i2s_sck <= 1'b0;
            i2s_ws  <= 1'b0;
            i2s_sd  <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            div_act <= div;
            cnt     <= 5'd31;
            i2s_sck <= 1'b0;
            i2s_ws  <= 1'b0;
            i2s_sd  <= 1'b0;
        end else begin
            if (wrap) begin
                div_cnt <= '0;
                div_act <= div;
                i2s_sck <= ~i2s_sck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall) begin
                cnt    <= cnt_nx;
                // WS leads each channel's MSB by one bit (cnt 15..30 is right)
                i2s_ws <= (cnt_nx >= 5'd15) && (cnt_nx != 5'd31);
                if (load) begin
                    i2s_sd <= empty ? 1'b0 : head[31];
                    shreg  <= empty ? 32'd0 : {head[30:0], 1'b0};
                end else begin
                    i2s_sd <= shreg[31];
                    shreg  <= {shreg[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_i2s.sv
// Directed bench for apb_i2s: register access, frame serialization, FIFO limits, underrun.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_apb_i2s;

    logic        i_clk;
    logic        i_rst_n;
    logic [11:0] apb_paddr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;
    logic        i2s_sck;
    logic        i2s_ws;
    logic        i2s_sd;

    int total = 0;
    int bad   = 0;

    apb_i2s #(.FIFO_DEPTH(4), .DIV_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .apb_paddr   (apb_paddr),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr),
        .i2s_sck     (i2s_sck),
        .i2s_ws      (i2s_ws),
        .i2s_sd      (i2s_sd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b1;
        apb_paddr   = a;
        apb_pwdata  = d;
        tick();
        apb_penable = 1'b1;
        #1;
        err = apb_pslverr;
        tick();
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic err);
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
        apb_paddr   = a;
        tick();
        apb_penable = 1'b1;
        #1;
        d   = apb_prdata;
        err = apb_pslverr;
        tick();
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
    endtask

    // Samples SD/WS on the 32 SCK rising edges following the first one after EN goes high.
    task automatic capture_frame(output logic [31:0] sdw, output logic [31:0] wsw,
                                 output int first_rise, output int period);
        int   n;
        int   last;
        logic prev;
        n = 0; last = 0; first_rise = 0; period = 0;
        sdw = '0; wsw = '0;
        prev = i2s_sck;
        for (int cyc = 1; cyc <= 400 && n < 33; cyc++) begin
            tick();
            if (i2s_sck && !prev) begin
                n++;
                if (n == 1) first_rise = cyc;
                if (n == 2) period = cyc - last;
                if (n >= 2) begin
                    sdw[31 - (n - 2)] = i2s_sd;
                    wsw[31 - (n - 2)] = i2s_ws;
                end
                last = cyc;
            end
            prev = i2s_sck;
        end
        chk("frame_rises", n, 33);
    endtask

    logic [31:0] rd;
    logic        err;
    logic [31:0] sdw;
    logic [31:0] wsw;
    int          fr;
    int          per;
    logic        sd_seen;

    initial begin
        i_rst_n     = 1'b0;
        apb_paddr   = '0;
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
        apb_pwdata  = '0;

        // reset state
        #12;
        chk("rst_i2s", {29'd0, i2s_sck, i2s_ws, i2s_sd}, 32'd0);
        chk("rst_prdata", apb_prdata, 32'd0);
        chk("rst_pslverr_pready", {30'd0, apb_pslverr, apb_pready}, 32'd1);
        #11;
        i_rst_n = 1'b1;
        tick();
        apb_rd(12'h8, rd, err); chk("rst_status", rd, 32'h2);
        apb_rd(12'h4, rd, err); chk("rst_clkdiv", rd, 32'h3);
        apb_rd(12'h0, rd, err); chk("rst_ctrl", rd, 32'h0);

        // single frame at DIV=1
        apb_wr(12'h4, 32'h1, err);
        apb_wr(12'hC, 32'hA5A5_3C3C, err); chk("push1_err", {31'd0, err}, 32'd0);
        apb_rd(12'h8, rd, err); chk("status_one", rd, 32'h10);
        apb_wr(12'h0, 32'h1, err);
        capture_frame(sdw, wsw, fr, per);
        chk("first_rise", fr, 2);
        chk("sck_period", per, 4);
        chk("frame_sd", sdw, 32'hA5A5_3C3C);
        chk("frame_ws", wsw, 32'h0001_FFFE);
        apb_rd(12'h8, rd, err); chk("status_drained", rd, 32'h2);

        // underrun on the following frame
        ticks(10);
        apb_rd(12'h8, rd, err); chk("underrun_set", rd, 32'h6);
        sd_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            sd_seen = sd_seen | i2s_sd;
        end
        chk("underrun_sd", {31'd0, sd_seen}, 32'd0);
        apb_wr(12'h8, 32'h4, err);
        apb_rd(12'h8, rd, err); chk("underrun_w1c", rd, 32'h2);
        ticks(20);
        apb_rd(12'h8, rd, err); chk("underrun_again", rd, 32'h6);

        // EN cleared mid-frame, resume from frame start
        apb_wr(12'h0, 32'h0, err);
        apb_wr(12'h8, 32'h4, err);
        apb_wr(12'h0, 32'h2, err);
        apb_wr(12'hC, 32'h1234_5678, err);
        apb_wr(12'hC, 32'hCAFE_F00D, err);
        apb_rd(12'h8, rd, err); chk("status_two", rd, 32'h20);
        apb_wr(12'h0, 32'h1, err);
        ticks(40);
        apb_wr(12'h0, 32'h0, err);
        tick();
        chk("dis_outputs", {29'd0, i2s_sck, i2s_ws, i2s_sd}, 32'd0);
        apb_rd(12'h8, rd, err); chk("dis_level", rd, 32'h10);
        apb_wr(12'h0, 32'h1, err);
        capture_frame(sdw, wsw, fr, per);
        chk("resume_first_rise", fr, 2);
        chk("resume_sd", sdw, 32'hCAFE_F00D);

        // FIFO full with EN=0
        apb_wr(12'h0, 32'h0, err);
        apb_wr(12'h0, 32'h2, err);
        apb_wr(12'h8, 32'h4, err);
        for (int i = 0; i < 4; i++) begin
            apb_wr(12'hC, 32'h1111_0000 + i, err);
            chk("fill_err", {31'd0, err}, 32'd0);
        end
        apb_wr(12'hC, 32'hDEAD_BEEF, err); chk("overflow_err", {31'd0, err}, 32'd1);
        apb_rd(12'h8, rd, err); chk("status_full", rd, 32'h41);
        apb_rd(12'hC, rd, err); chk("txdata_reads0", rd, 32'h0);
        apb_wr(12'h0, 32'h2, err);
        apb_rd(12'h8, rd, err); chk("status_cleared", rd, 32'h2);
        apb_rd(12'h0, rd, err); chk("ctrl_clr_reads0", rd, 32'h0);

        // bad address
        apb_rd(12'h10, rd, err);
        chk("bad_rd_data", rd, 32'h0);
        chk("bad_rd_err", {31'd0, err}, 32'd1);
        apb_wr(12'h10, 32'h1, err); chk("bad_wr_err", {31'd0, err}, 32'd1);
        apb_rd(12'h0, rd, err); chk("bad_wr_ctrl", rd, 32'h0);
        apb_wr(12'h14, 32'hFF, err);
        apb_rd(12'h4, rd, err); chk("bad_wr_clkdiv", rd, 32'h1);

        // reset mid-frame
        apb_wr(12'hC, 32'hFFFF_FFFF, err);
        apb_wr(12'h0, 32'h1, err);
        ticks(50);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_i2s", {29'd0, i2s_sck, i2s_ws, i2s_sd}, 32'd0);
        #7;
        i_rst_n = 1'b1;
        tick();
        apb_rd(12'h8, rd, err); chk("midrst_status", rd, 32'h2);
        apb_rd(12'h4, rd, err); chk("midrst_clkdiv", rd, 32'h3);
        apb_rd(12'h0, rd, err); chk("midrst_ctrl", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
